hazard_stall_unit: RTL

Pipeline stall/flush controller for the 5-stage RV32 (RVC) core. It handles the hazards that forwarding cannot resolve: load-use, and branch-in-ID operand dependencies. It also handles I/D-cache stalls and taken-branch squash, including a redirect that arrives while a fetch is outstanding. It sits beside the forwarding unit and gates PC, IF/ID and ID/EX register updates.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_dep_cmp.sv | 18 +
 rtl/hazard_stall_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Holds the cause-state encoding, the x0 register index and the NOP
// encoding that flush/bubble consumers load into IF/ID and ID/EX.
package hazard_pkg;

    // Cause of the stall decision taken in the previous cycle.
    typedef enum logic [1:0] {
        STATE_RUN    = 2'd0,
        STATE_HAZ    = 2'd1,
        STATE_FREEZE = 2'd2
    } haz_state_t;

    // x0 is hard-wired zero and can never create a true dependency.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Canonical RV32I NOP (addi x0, x0, 0) used when IF/ID or ID/EX is
    // flushed or bubbled.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True when a source operand that is really read matches a producer
    // destination that is not x0.
    function automatic logic reg_dep(input logic       uses,
                                     input logic [4:0] rs,
                                     input logic [4:0] rd);
        return uses && (rs != REG_X0) && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_dep_cmp.sv
// Single source-vs-destination dependency comparator.
// Asserts match when the ID instruction reads rs, rs is not x0, and rs
// equals the producer destination rd.
module hazard_dep_cmp
    import hazard_pkg::*;
(
    input  logic       uses,
    input  logic [4:0] rs,
    input  logic [4:0] rd,
    output logic       match
);

    // Purely combinational compare; zero latency into the stall logic.
    always_comb begin
        match = reg_dep(uses, rs, rd);
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage RV32 (RVC) pipeline.
// Resolves load-use and branch-in-ID operand hazards, I/D-cache stalls and
// taken-branch squash, including a redirect issued during an outstanding
// fetch (kill_pending). Optional perf counters are built when the macro
// HAZARD_PERF_CNT_EN is defined.
//
// Pipeline enable handshake: PC_WRITE / IFID_WRITE are "may update"
// enables, IFID_FLUSH / IDEX_BUBBLE force the NOP encoding into the
// register on the same edge, and FREEZE holds every pipeline register.
// All five are combinational from the inputs plus the registered state.
module hazard_stall_unit
    import hazard_pkg::*;
`ifdef HAZARD_PERF_CNT_EN
#(
    parameter int unsigned XLEN_CNT = 32
)
`endif
(
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          IFID_RS1,
    input  logic [4:0]          IFID_RS2,
    input  logic                IFID_USES_RS1,
    input  logic                IFID_USES_RS2,
    input  logic                IFID_IS_BRANCH,
    input  logic [4:0]          IDEX_RD,
    input  logic                IDEX_RegWrite,
    input  logic                IDEX_MemRead,
    input  logic [4:0]          EXMEM_RD,
    input  logic                EXMEM_MemRead,
    input  logic                BRANCH_TAKEN,
    input  logic                ICACHE_STALL,
    input  logic                DCACHE_STALL,
    output logic                PC_WRITE,
    output logic                IFID_WRITE,
    output logic                IFID_FLUSH,
    output logic                IDEX_BUBBLE,
    output logic                FREEZE,
`ifdef HAZARD_PERF_CNT_EN
    output logic [XLEN_CNT-1:0] HAZ_CNT,
    output logic [XLEN_CNT-1:0] FRZ_CNT,
`endif
    output haz_state_t          dbg_state,
    output logic                dbg_kill_pending
);

    // Dependency matches against the EX and MEM producers.
    logic lu_rs1, lu_rs2;
    logic bx_rs1, bx_rs2;
    logic bm_rs1, bm_rs2;

    hazard_dep_cmp u_cmp_lu_rs1 (.uses(IFID_USES_RS1), .rs(IFID_RS1), .rd(IDEX_RD),  .match(lu_rs1));
    hazard_dep_cmp u_cmp_lu_rs2 (.uses(IFID_USES_RS2), .rs(IFID_RS2), .rd(IDEX_RD),  .match(lu_rs2));
    hazard_dep_cmp u_cmp_bx_rs1 (.uses(IFID_USES_RS1), .rs(IFID_RS1), .rd(IDEX_RD),  .match(bx_rs1));
    hazard_dep_cmp u_cmp_bx_rs2 (.uses(IFID_USES_RS2), .rs(IFID_RS2), .rd(IDEX_RD),  .match(bx_rs2));
    hazard_dep_cmp u_cmp_bm_rs1 (.uses(IFID_USES_RS1), .rs(IFID_RS1), .rd(EXMEM_RD), .match(bm_rs1));
    hazard_dep_cmp u_cmp_bm_rs2 (.uses(IFID_USES_RS2), .rs(IFID_RS2), .rd(EXMEM_RD), .match(bm_rs2));

    logic load_use;
    logic br_ex;
    logic br_mem;
    logic hazard;

    // Hazard classification. A load feeding a branch raises br_ex now and
    // br_mem next cycle, which yields its two bubbles naturally.
    always_comb begin
        load_use = IDEX_MemRead && IDEX_RegWrite && (lu_rs1 || lu_rs2);
        br_ex    = IFID_IS_BRANCH && IDEX_RegWrite && (bx_rs1 || bx_rs2);
        br_mem   = IFID_IS_BRANCH && EXMEM_MemRead && (bm_rs1 || bm_rs2);
        hazard   = load_use || br_ex || br_mem;
    end

    haz_state_t state_q, state_d;
    logic       kill_pending_q, kill_pending_d;
    logic       kill_clear;

    // Registered cause state and outstanding-fetch kill flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= STATE_RUN;
            kill_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            kill_pending_q <= kill_pending_d;
        end
    end

    // Priority decode of pipeline enables plus next-state computation.
    always_comb begin
        PC_WRITE       = 1'b1;
        IFID_WRITE     = 1'b1;
        IFID_FLUSH     = 1'b0;
        IDEX_BUBBLE    = 1'b0;
        FREEZE         = 1'b0;
        state_d        = STATE_RUN;
        kill_pending_d = kill_pending_q;

        // The wrong-path fetch returns on the first fully unstalled cycle.
        kill_clear = kill_pending_q && !ICACHE_STALL && !DCACHE_STALL;

        if (rst) begin
            PC_WRITE       = 1'b0;
            IFID_WRITE     = 1'b0;
            IFID_FLUSH     = 1'b1;
            IDEX_BUBBLE    = 1'b1;
            kill_pending_d = 1'b0;
            kill_clear     = 1'b0;
        end else if (DCACHE_STALL) begin
            // Whole pipe holds; a taken branch in ID will be re-presented.
            FREEZE     = 1'b1;
            PC_WRITE   = 1'b0;
            IFID_WRITE = 1'b0;
            state_d    = STATE_FREEZE;
        end else if (hazard) begin
            // Operands not ready: hold front end, bubble into EX.
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
            IDEX_BUBBLE = 1'b1;
            state_d     = STATE_HAZ;
        end else if (BRANCH_TAKEN) begin
            // Redirect wins over an instruction miss; the miss in flight
            // returns a wrong-path word that must be squashed later.
            PC_WRITE   = 1'b1;
            IFID_FLUSH = 1'b1;
            if (ICACHE_STALL) begin
                kill_pending_d = 1'b1;
                kill_clear     = 1'b0;
            end
        end else if (ICACHE_STALL) begin
            // Feed bubbles into ID so the backend keeps draining.
            PC_WRITE   = 1'b0;
            IFID_FLUSH = 1'b1;
        end

        if (kill_clear) begin
            IFID_FLUSH     = 1'b1;
            kill_pending_d = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Bubble and freeze cycle counters, wrapping at 2^XLEN_CNT.
    always_ff @(posedge clk) begin
        if (rst) begin
            HAZ_CNT <= '0;
            FRZ_CNT <= '0;
        end else begin
            if (IDEX_BUBBLE) HAZ_CNT <= HAZ_CNT + 1'b1;
            if (FREEZE)      FRZ_CNT <= FRZ_CNT + 1'b1;
        end
    end
`endif

    // Debug visibility of the internal registers.
    always_comb begin
        dbg_state        = state_q;
        dbg_kill_pending = kill_pending_q;
    end

endmodule
